// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the regfile_sb register file
package regfile_pkg;

    localparam int REGFILE_NREG   = 32;
    localparam int REGFILE_DATA_W = 32;
    localparam int ADDR_W         = $clog2(REGFILE_NREG);

    typedef logic [ADDR_W-1:0]         creg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with flush > mark > clear priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = REGFILE_NREG,
    parameter int NR   = 4,
    parameter int NW   = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic [NW-1:0]           mark_valid,
    input  logic [$clog2(NREG)-1:0] mark_addr [NW],
    input  logic [NW-1:0]           clr_valid,
    input  logic [$clog2(NREG)-1:0] clr_addr [NW],
    input  logic [$clog2(NREG)-1:0] ra [NR],
    output logic [NR-1:0]           rbusy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears applied first so a same-cycle mark overrides the completing producer.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NW; j++) begin
            if (clr_valid[j]) busy_d[clr_addr[j]] = 1'b0;
        end
        for (int i = 0; i < NW; i++) begin
            if (mark_valid[i]) busy_d[mark_addr[i]] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NR; i++) begin
            rbusy[i] = busy_q[ra[i]];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with scoreboard; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NREG   = REGFILE_NREG,
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int NR     = 4,
    parameter int NW     = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [$clog2(NREG)-1:0] ra [NR],
    output logic [DATA_W-1:0]       rd [NR],
    output logic [NR-1:0]           rbusy,
    input  logic [NW-1:0]           we,
    input  logic [$clog2(NREG)-1:0] wa [NW],
    input  logic [DATA_W-1:0]       wd [NW],
    input  logic [NW-1:0]           wclr,
    input  logic [NW-1:0]           mark_valid,
    input  logic [$clog2(NREG)-1:0] mark_addr [NW],
    input  logic                    flush
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NW-1:0]     clr_valid;
    logic [NR-1:0]     sb_rbusy;

    // Ascending port order lets the youngest (highest-index) writer win.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NW; j++) begin
            if (we[j]) regs_d[wa[j]] = wd[j];
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        clr_valid = '0;
        for (int j = 0; j < NW; j++) begin
            clr_valid[j] = we[j] & wclr[j];
        end
    end

    regfile_scoreboard #(
        .NREG(NREG),
        .NR  (NR),
        .NW  (NW)
    ) u_scoreboard (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .mark_valid(mark_valid),
        .mark_addr (mark_addr),
        .clr_valid (clr_valid),
        .clr_addr  (wa),
        .ra        (ra),
        .rbusy     (sb_rbusy)
    );

`ifdef REGFILE_BYPASS_EN
    logic [NR-1:0] byp_clr;

    always_comb begin
        byp_clr = '0;
        for (int i = 0; i < NR; i++) begin
            rd[i] = regs_q[ra[i]];
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa[j] == ra[i] && ra[i] != '0) begin
                    rd[i]      = wd[j];
                    byp_clr[i] = wclr[j];
                end
            end
        end
        rbusy = sb_rbusy & ~byp_clr;
    end
`else
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rd[i] = regs_q[ra[i]];
        end
        rbusy = sb_rbusy;
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed table-driven bench for regfile_sb
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  ra [4];
    logic [31:0] rd [4];
    logic [3:0]  rbusy;
    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [1:0]  wclr;
    logic [1:0]  mark_valid;
    logic [4:0]  mark_addr [2];
    logic        flush;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk       (clk),
        .resetn    (resetn),
        .ra        (ra),
        .rd        (rd),
        .rbusy     (rbusy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .wclr      (wclr),
        .mark_valid(mark_valid),
        .mark_addr (mark_addr),
        .flush     (flush)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  wclr;
        logic [1:0]  mv;
        logic [4:0]  ma0;
        logic [4:0]  ma1;
        logic        fl;
        logic [4:0]  ca;
        logic [31:0] ed;
        logic        eb;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic idle();
        we = '0; wclr = '0; mark_valid = '0; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wa[k] = '0; wd[k] = '0; mark_addr[k] = '0;
        end
    endtask

    task automatic set_ra(input logic [4:0] a);
        for (int k = 0; k < 4; k++) ra[k] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] a, input logic [31:0] ed, input logic eb);
        set_ra(a);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_rd%0d", name, k), rd[k], ed);
            chk($sformatf("%s_busy%0d", name, k), {31'b0, rbusy[k]}, {31'b0, eb});
        end
    endtask

    initial begin
        vecs[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        2'b00, 2'b00, 5'd0,  5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[1]  = '{2'b11, 5'd7,  32'h11111111, 5'd7,  32'h22222222, 2'b00, 2'b00, 5'd0,  5'd0,  1'b0, 5'd7,  32'h22222222, 1'b0};
        vecs[2]  = '{2'b10, 5'd0,  32'h0,        5'd0,  32'hFFFFFFFF, 2'b00, 2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0};
        vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        2'b00, 2'b01, 5'd3,  5'd0,  1'b0, 5'd3,  32'h0,        1'b1};
        vecs[4]  = '{2'b01, 5'd3,  32'h5,        5'd0,  32'h0,        2'b01, 2'b00, 5'd0,  5'd0,  1'b0, 5'd3,  32'h5,        1'b0};
        vecs[5]  = '{2'b01, 5'd3,  32'hAB,       5'd0,  32'h0,        2'b01, 2'b10, 5'd0,  5'd3,  1'b0, 5'd3,  32'hAB,       1'b1};
        vecs[6]  = '{2'b01, 5'd3,  32'hCD,       5'd0,  32'h0,        2'b01, 2'b10, 5'd0,  5'd3,  1'b1, 5'd3,  32'hCD,       1'b0};
        vecs[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        2'b00, 2'b01, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0};
        vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        2'b00, 2'b11, 5'd11, 5'd10, 1'b0, 5'd10, 32'h0,        1'b1};
        vecs[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        2'b00, 2'b00, 5'd0,  5'd0,  1'b1, 5'd11, 32'h0,        1'b0};
        vecs[10] = '{2'b10, 5'd0,  32'h0,        5'd31, 32'h12345678, 2'b10, 2'b00, 5'd0,  5'd0,  1'b0, 5'd31, 32'h12345678, 1'b0};

        idle();
        set_ra(5'd0);
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;

        for (int r = 0; r < 32; r++) begin
            chk_reg($sformatf("reset_r%0d", r), r[4:0], 32'h0, 1'b0);
        end

        for (int n = 0; n < 11; n++) begin
            we = vecs[n].we; wclr = vecs[n].wclr; mark_valid = vecs[n].mv; flush = vecs[n].fl;
            wa[0] = vecs[n].wa0; wd[0] = vecs[n].wd0;
            wa[1] = vecs[n].wa1; wd[1] = vecs[n].wd1;
            mark_addr[0] = vecs[n].ma0; mark_addr[1] = vecs[n].ma1;
            tick();
            idle();
            chk_reg($sformatf("vec%0d", n), vecs[n].ca, vecs[n].ed, vecs[n].eb);
        end

        // Same-cycle write with clear on a busy register.
        we = 2'b10; wa[1] = 5'd9; wd[1] = 32'h1111;
        tick();
        idle();
        mark_valid = 2'b01; mark_addr[0] = 5'd9;
        tick();
        idle();
        we = 2'b10; wclr = 2'b10; wa[1] = 5'd9; wd[1] = 32'hCAFE;
        set_ra(5'd0);
        ra[2] = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_rd", rd[2], 32'hCAFE);
        chk("byp_same_busy", {31'b0, rbusy[2]}, 32'h0);
`else
        chk("nobyp_same_rd", rd[2], 32'h1111);
        chk("nobyp_same_busy", {31'b0, rbusy[2]}, 32'h1);
`endif
        tick();
        idle();
        chk_reg("byp_after", 5'd9, 32'hCAFE, 1'b0);

        // Reset discards a pending write and mark.
        mark_valid = 2'b01; mark_addr[0] = 5'd4;
        tick();
        idle();
        chk_reg("r4_busy", 5'd4, 32'h0, 1'b1);
        we = 2'b01; wa[0] = 5'd4; wd[0] = 32'h77; mark_valid = 2'b10; mark_addr[1] = 5'd4;
        resetn = 1'b0;
        tick();
        idle();
        resetn = 1'b1;
        chk_reg("rst_r4", 5'd4, 32'h0, 1'b0);
        chk_reg("rst_r5", 5'd5, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with an integrated scoreboard, the next-generation register file for the dual-issue mycpu pipeline. It provides NR combinational read ports and NW synchronous write ports, keeps register 0 hard-wired to zero, and tracks one busy bit per register so decode can stall on operands still owned by an in-flight multi-cycle producer (load, mul/div). Optional write-to-read bypass removes the one-cycle write-then-read bubble.

## Interface
- NREG, default 32: number of architectural registers; power of two, ≥ 2.
- DATA_W, default 32: register width in bits.
- NR, default 4: number of read ports.
- NW, default 2: number of write ports; higher index = younger instruction.
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- ra[NR]  in  NR×$clog2(NREG)  read addresses.
- rd[NR]  out  NR×DATA_W  read data, combinational from ra.
- rbusy[NR]  out  NR  busy bit of the register addressed by ra[i]; always 0 for address 0.
- we[NW]  in  NW  write enables.
- wa[NW]  in  NW×$clog2(NREG)  write addresses.
- wd[NW]  in  NW×DATA_W  write data.
- wclr[NW]  in  NW  when set together with we[i], the write also clears wa[i]'s busy bit.
- mark_valid  in  NW  per-lane issue: set busy bit of mark_addr[i].
- mark_addr[NW]  in  NW×$clog2(NREG)  destination registers being issued.
- flush  in  1  clears every busy bit at next edge; register contents unaffected.

## Operation
- Register 0: writes, marks and clears to address 0 ignored; rd returns 0, rbusy returns 0.
- Write: we[i] && wa[i]≠0 → regs[wa[i]] ← wd[i] at edge. Same address on several write ports → highest-index port wins.
- Scoreboard next state per register r (priority high→low): resetn=0 → 0; flush → 0; any mark_valid[i] with mark_addr[i]=r → 1; any we[j]&&wclr[j] with wa[j]=r → 0; else hold.
- Mark and clear of same register in same cycle → mark wins (new producer supersedes the completing one).
- flush together with mark in same cycle → flush wins; all busy bits 0.
- rd[i]/rbusy[i] reflect state as of the last edge, unless bypass is compiled in (see Configuration).
- No arithmetic; all widths exact, no truncation. Out-of-range addresses impossible (NREG power of two).

## Timing
- Reset: all registers 0, all busy bits 0; rd all 0 and rbusy all 0 in the first cycle after reset.
- Reset mid-operation: pending we/mark in the reset cycle are discarded.
- Write latency: 1 cycle (visible at rd the cycle after the write edge); 0 cycles with bypass.
- Mark latency: rbusy rises the cycle after mark_valid; never bypassed.
- Clear latency: rbusy falls the cycle after we&&wclr; 0 cycles with bypass.
- Read ports are purely combinational; no read enables, no stalls inside the block.

## Configuration
- REGFILE_BYPASS_EN defined: for each read port, if any we[j] with wa[j]=ra[i]≠0 this cycle, rd[i] = wd of the highest such j; if that port also has wclr[j], rbusy[i]=0 this cycle.
- Undefined: rd/rbusy come only from stored state; a same-cycle write is seen one cycle later. Scoreboard and write behaviour identical in both builds.

## Structure
- Package regfile_pkg: creg_addr_t, word_t, NREG/DATA_W defaults, localparam ADDR_W.
- Sub-module regfile_scoreboard: busy-bit array with mark/clear/flush priority logic and per-port rbusy lookup; data array and bypass muxing stay in the top.

## Test plan
- Reset then read all 32 registers on 4 ports → every rd=0, rbusy=0; write r5=0xDEADBEEF, read next cycle → 0xDEADBEEF.
- we[0] and we[1] both to r7 with 0x11111111 / 0x22222222 → r7=0x22222222; write 0xFFFFFFFF to r0 → r0 still reads 0.
- mark r3 → rbusy for r3 =1 next cycle; we[0] r3=0x5 wclr=1 → rbusy=0 and rd=0x5 next cycle.
- Same cycle mark r3 on lane 1 and we+wclr r3 on port 0 → r3 busy=1, data=port-0 value; add flush same cycle → busy=0.
- Bypass build: we[1] r9=0xCAFE with wclr while ra[2]=r9 and r9 busy → same cycle rd[2]=0xCAFE, rbusy[2]=0; non-bypass build → old value and rbusy=1 that cycle.
- Assert resetn=0 while r4 busy and we on r4 pending → r4=0, busy=0 next cycle.
